// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for a shared single-issue resource.
// Sequences start/done per transaction and aborts stalled transactions after TIMEOUT cycles.
module mem_port_arbiter #(
   parameter int size    = 8,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0,
   input  logic            req1,
   input  logic [size-1:0] addr0,
   input  logic [size-1:0] addr1,
   input  logic            done,
   output logic            grant0,
   output logic            grant1,
   output logic            select,
   output logic [size-1:0] addr_out,
   output logic            start,
   output logic            ack0,
   output logic            ack1,
   output logic            timeout,
   output logic            busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          grant0_q, grant0_d;
   logic          grant1_q, grant1_d;
   logic          select_q, select_d;
   logic          start_q, start_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          timeout_q, timeout_d;
   logic          busy_q, busy_d;
   logic          req0_m, req1_m;
   logic          done_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         grant0_q  <= 1'b0;
         grant1_q  <= 1'b0;
         select_q  <= 1'b0;
         start_q   <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         grant0_q  <= grant0_d;
         grant1_q  <= grant1_d;
         select_q  <= select_d;
         start_q   <= start_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   // A port acknowledged this cycle cannot immediately re-win; this yields the idle gap.
   assign req0_m  = req0 & ~ack0_q;
   assign req1_m  = req1 & ~ack1_q;
   assign done_ok = done & ~start_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req0_m && req1_m)
               state_d = last_q ? GRANT0 : GRANT1;
            else if (req0_m)
               state_d = GRANT0;
            else if (req1_m)
               state_d = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (done_ok || cnt_q == TMAX)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant0_d  = 1'b0;
      grant1_d  = 1'b0;
      busy_d    = 1'b0;
      start_d   = 1'b0;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      timeout_d = 1'b0;
      select_d  = select_q;
      last_d    = last_q;
      cnt_d     = (state_q == IDLE) ? '0 : CW'(cnt_q + 1'b1);

      case (state_d)
         GRANT0: begin
            grant0_d = 1'b1;
            busy_d   = 1'b1;
            select_d = 1'b0;
         end
         GRANT1: begin
            grant1_d = 1'b1;
            busy_d   = 1'b1;
            select_d = 1'b1;
         end
         default: ;
      endcase

      if (state_q == IDLE && state_d != IDLE) begin
         start_d = 1'b1;
         last_d  = (state_d == GRANT1);
      end

      // Completion beats timeout when both happen in the same cycle.
      if (state_q != IDLE && state_d == IDLE) begin
         if (done_ok) begin
            ack0_d = (state_q == GRANT0);
            ack1_d = (state_q == GRANT1);
         end else begin
            timeout_d = 1'b1;
         end
      end
   end

   assign grant0   = grant0_q;
   assign grant1   = grant1_q;
   assign select   = select_q;
   assign start    = start_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign timeout  = timeout_q;
   assign busy     = busy_q;
   assign addr_out = select_q ? addr1 : addr0;

endmodule
